// File: rtl/chiplet_types_pkg.sv
// Shared types and endpoint address map for the endpoint TX driver.
package chiplet_types_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WDATA,
    WSTART,
    WSEND,
    DONE,
    ERR
  } tx_driver_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_BUS_DATA = 2'd2,
    ERR_BUS_CTRL = 2'd3
  } tx_driver_err_e;

  localparam logic [31:0] EP_TX_SEND_ADDR        = 32'h0000_1004;
  localparam logic [31:0] EP_TX_CACHE_START_ADDR = 32'h0000_2000;
  localparam logic [3:0]  STROBE_ALL             = 4'hF;

endpackage

// File: rtl/endpoint_tx_driver_if.sv
// Endpoint peripheral bus port seen from the initiator (master) and responder (slave).
interface endpoint_tx_driver_if;
  // A write is requested while bus_wen=1 and completes in the first cycle where
  // bus_request_stall=0; the request is held unchanged while stalled, and
  // bus_error is meaningful only in that completing cycle.
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strobe;
  logic [31:0] bus_rdata;
  logic        bus_error;
  logic        bus_request_stall;

  modport master (
    output bus_addr, bus_wen, bus_ren, bus_wdata, bus_strobe,
    input  bus_rdata, bus_error, bus_request_stall
  );

  modport slave (
    input  bus_addr, bus_wen, bus_ren, bus_wdata, bus_strobe,
    output bus_rdata, bus_error, bus_request_stall
  );
endinterface

// File: rtl/endpoint_tx_driver_bus_write_req.sv
// Presents one write request on the bus while requested and flags its completion/error.
module endpoint_tx_driver_bus_write_req
  import chiplet_types_pkg::*;
(
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        bus_stall,
  input  logic        bus_error,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_wen,
  output logic [3:0]  bus_strobe,
  output logic        cpl,
  output logic        cpl_err
);
  // Request fields come from registered state, so they stay stable across stalls.
  assign bus_wen    = req_valid;
  assign bus_addr   = req_valid ? req_addr  : 32'h0;
  assign bus_wdata  = req_valid ? req_wdata : 32'h0;
  assign bus_strobe = req_valid ? STROBE_ALL : 4'h0;
  assign cpl        = req_valid && !bus_stall;
  assign cpl_err    = cpl && bus_error;
endmodule

// File: rtl/endpoint_tx_driver.sv
// Streams a packet into the endpoint TX cache, programs the slot start address, then triggers send.
module endpoint_tx_driver
  import chiplet_types_pkg::*;
#(
  parameter int          NUM_MSGS            = 4,
  parameter int          CACHE_NUM_WORDS     = 128,
  parameter logic [31:0] TX_SEND_ADDR        = EP_TX_SEND_ADDR,
  parameter logic [31:0] TX_CACHE_START_ADDR = EP_TX_CACHE_START_ADDR
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [$clog2(NUM_MSGS)-1:0]        cmd_slot,
  input  logic [$clog2(CACHE_NUM_WORDS)-1:0] cmd_start_word,
  input  logic [$clog2(CACHE_NUM_WORDS):0]   cmd_len_words,
  input  logic                               data_valid,
  output logic                               data_ready,
  input  logic [31:0]                        data,
  endpoint_tx_driver_if.master               bus,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [1:0]                         err_code,
  output tx_driver_state_e                   dbg_state
);
  localparam int SLOT_W = $clog2(NUM_MSGS);
  localparam int WORD_W = $clog2(CACHE_NUM_WORDS);
  localparam int LEN_W  = WORD_W + 1;
  localparam int SUM_W  = LEN_W + 1;

  tx_driver_state_e   state_q, state_d;
  tx_driver_err_e     err_code_q, err_code_d;
  logic [SLOT_W-1:0]  slot_q;
  logic [WORD_W-1:0]  start_q;
  logic [LEN_W-1:0]   len_q;
  logic [WORD_W-1:0]  cnt_q;
  logic [31:0]        hold_q;

  logic               req_valid;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               wr_cpl;
  logic               wr_err;
  logic [SUM_W-1:0]   span;
  logic               range_bad;
  logic               last_word;
  logic [29:0]        word_idx;
  logic               rdata_unused;

  // One bit wider than the length so start+len never wraps before the compare.
  assign span      = SUM_W'(cmd_start_word) + SUM_W'(cmd_len_words);
  assign range_bad = (cmd_len_words == '0) || (span > SUM_W'(CACHE_NUM_WORDS));
  assign last_word = ({1'b0, cnt_q} == (len_q - LEN_W'(1)));
  assign word_idx  = 30'(start_q) + 30'(cnt_q);

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          err_code_d = range_bad ? ERR_RANGE : ERR_NONE;
          state_d    = range_bad ? ERR : LOAD;
        end
      end
      LOAD: begin
        data_ready = 1'b1;
        if (data_valid) state_d = WDATA;
      end
      WDATA: begin
        req_valid = 1'b1;
        req_addr  = TX_CACHE_START_ADDR + {word_idx, 2'b00};
        req_wdata = hold_q;
        if (wr_cpl) begin
          if (wr_err) begin
            state_d    = ERR;
            err_code_d = ERR_BUS_DATA;
          end else begin
            state_d = last_word ? WSTART : LOAD;
          end
        end
      end
      WSTART: begin
        req_valid = 1'b1;
        req_addr  = 32'({slot_q, 2'b00});
        req_wdata = 32'({start_q, 2'b00});
        if (wr_cpl) begin
          state_d = wr_err ? ERR : WSEND;
          if (wr_err) err_code_d = ERR_BUS_CTRL;
        end
      end
      WSEND: begin
        req_valid = 1'b1;
        req_addr  = TX_SEND_ADDR;
        req_wdata = 32'(slot_q);
        if (wr_cpl) begin
          state_d = wr_err ? ERR : DONE;
          if (wr_err) err_code_d = ERR_BUS_CTRL;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      err_code_q <= ERR_NONE;
      slot_q     <= '0;
      start_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      if (state_q == IDLE && cmd_valid) begin
        slot_q  <= cmd_slot;
        start_q <= cmd_start_word;
        len_q   <= cmd_len_words;
        cnt_q   <= '0;
      end
      if (state_q == LOAD && data_valid) hold_q <= data;
      if (state_q == WDATA && wr_cpl && !wr_err) cnt_q <= cnt_q + WORD_W'(1);
    end
  end

  endpoint_tx_driver_bus_write_req u_write_req (
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .bus_stall  (bus.bus_request_stall),
    .bus_error  (bus.bus_error),
    .bus_addr   (bus.bus_addr),
    .bus_wdata  (bus.bus_wdata),
    .bus_wen    (bus.bus_wen),
    .bus_strobe (bus.bus_strobe),
    .cpl        (wr_cpl),
    .cpl_err    (wr_err)
  );

  assign bus.bus_ren  = 1'b0;
  assign rdata_unused = ^bus.bus_rdata;
  assign busy         = (state_q != IDLE);
  assign err_code     = err_code_q;
  assign dbg_state    = state_q;
endmodule
